// File: rtl/alu_pkg.sv
// ============================================================================
// alu_pkg : shared types and defaults for the multi-precision add sequencer
// Revision: 1.0
// ============================================================================
`default_nettype none

package alu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DWIDTH_DEF = 8;
  localparam int WORDS_DEF  = 4;

  function automatic int cnt_width(input int words);
    return (words <= 1) ? 1 : $clog2(words);
  endfunction

endpackage

`default_nettype wire

// File: rtl/mp_add_seq_cla.sv
// ============================================================================
// mp_add_seq_cla : DWIDTH-bit carry look-ahead adder shared by the sequencer
// Revision: 1.0
// ============================================================================
`default_nettype none

module mp_add_seq_cla #(
  parameter int DWIDTH = 8
) (
  input  logic [DWIDTH-1:0] a,
  input  logic [DWIDTH-1:0] b,
  input  logic              ci,
  output logic [DWIDTH-1:0] sum,
  output logic              co
);

  logic [DWIDTH-1:0] g;
  logic [DWIDTH-1:0] p;

  assign g = a & b;
  assign p = a ^ b;

  // Carries expressed in generate/propagate form; flattened into look-ahead logic.
  always_comb begin : cla_carry
    logic c;
    c   = ci;
    sum = '0;
    for (int i = 0; i < DWIDTH; i++) begin
      sum[i] = p[i] ^ c;
      c      = g[i] | (p[i] & c);
    end
    co = c;
  end

endmodule

`default_nettype wire

// File: rtl/mp_add_seq.sv
// ============================================================================
// mp_add_seq : WORDS*DWIDTH-bit add/subtract, one chunk per cycle LSB first
// Revision: 1.0
// ============================================================================
`default_nettype none

module mp_add_seq
  import alu_pkg::*;
#(
  parameter int DWIDTH = DWIDTH_DEF,
  parameter int WORDS  = WORDS_DEF
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [WORDS*DWIDTH-1:0] op_a,
  input  logic [WORDS*DWIDTH-1:0] op_b,
  input  logic                    sub,
  input  logic                    cin,
  output logic                    res_valid,
  input  logic                    res_ready,
  output logic [WORDS*DWIDTH-1:0] result,
  output logic                    carry_out,
  output logic                    overflow,
  output logic                    busy
);

  localparam int CW = cnt_width(WORDS);
  localparam int W  = WORDS * DWIDTH;
  localparam logic [CW-1:0] LAST = CW'(WORDS - 1);

  state_t            state, state_nx;
  logic              ready_en;
  logic [W-1:0]      a_q, b_q;
  logic              sub_q;
  logic [CW-1:0]     cnt;
  logic              carry_q;
  logic [DWIDTH-1:0] res_w   [WORDS];
  logic [DWIDTH-1:0] a_chunk [WORDS];
  logic [DWIDTH-1:0] b_chunk [WORDS];

  logic [DWIDTH-1:0] in1, in2, sum;
  logic              add_co;
  logic              cnt_last, accept, release_res;

  for (genvar i = 0; i < WORDS; i++) begin : g_chunk
    assign a_chunk[i]                  = a_q[i*DWIDTH +: DWIDTH];
    assign b_chunk[i]                  = b_q[i*DWIDTH +: DWIDTH];
    assign result[i*DWIDTH +: DWIDTH]  = res_w[i];
  end

  assign in1 = a_chunk[cnt];
  assign in2 = sub_q ? ~b_chunk[cnt] : b_chunk[cnt];

  mp_add_seq_cla #(.DWIDTH(DWIDTH)) u_adder (
    .a   (in1),
    .b   (in2),
    .ci  (carry_q),
    .sum (sum),
    .co  (add_co)
  );

  assign cnt_last    = (cnt == LAST);
  assign accept      = cmd_valid & cmd_ready;
  assign release_res = res_valid & res_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    cmd_ready = 1'b0;
    res_valid = 1'b0;
    busy      = 1'b0;
    case (state)
      IDLE: begin
        cmd_ready = ready_en;
        if (accept) state_nx = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (cnt_last) state_nx = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        res_valid = 1'b1;
        if (release_res) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_en  <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      sub_q     <= 1'b0;
      cnt       <= '0;
      carry_q   <= 1'b0;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
      for (int i = 0; i < WORDS; i++) res_w[i] <= '0;
    end else begin
      ready_en <= 1'b1;
      if (accept) begin
        a_q       <= op_a;
        b_q       <= op_b;
        sub_q     <= sub;
        carry_q   <= sub ? 1'b1 : cin;
        cnt       <= '0;
        carry_out <= 1'b0;
        overflow  <= 1'b0;
        for (int i = 0; i < WORDS; i++) res_w[i] <= '0;
      end else if (state == RUN) begin
        res_w[cnt] <= sum;
        carry_q    <= add_co;
        cnt        <= cnt_last ? '0 : cnt + 1'b1;
        // Final chunk carries the sign bits used for the signed overflow flag.
        if (cnt_last) begin
          carry_out <= add_co;
          overflow  <= (in1[DWIDTH-1] == in2[DWIDTH-1]) &
                       (sum[DWIDTH-1] != in1[DWIDTH-1]);
        end
      end
    end
  end

endmodule

`default_nettype wire
